// File: rtl/regfile_arb_pkg.sv
// -----------------------------------------------------------------------------
// regfile_arb_pkg
// Shared constants and types for the register-file write arbiter.
//   RF_AW     : register address width (32-entry file -> 5 bits)
//   RF_DW     : register write data width
//   RF_NREGS  : number of architectural registers
//   arb_state_e : arbiter FSM states (ARB = free round-robin, LOCKED = burst)
// -----------------------------------------------------------------------------
package regfile_arb_pkg;

  localparam int RF_AW    = 5;
  localparam int RF_DW    = 32;
  localparam int RF_NREGS = 32;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage : regfile_arb_pkg

// File: rtl/regfile_write_arbiter_decode.sv
// -----------------------------------------------------------------------------
// wr_decode5to32
// Combinational 5-bit to 32-bit one-hot decoder with enable.
//   en     : in  1  decode enable; output is all-zero when low
//   addr   : in  5  register address
//   onehot : out 32 one-hot register select (addr 0 -> bit 0)
// -----------------------------------------------------------------------------
module wr_decode5to32
  import regfile_arb_pkg::*;
(
  input  logic                en,
  input  logic [RF_AW-1:0]    addr,
  output logic [RF_NREGS-1:0] onehot
);

  // One-hot decode of the address, suppressed when not enabled
  always_comb begin
    onehot = {RF_NREGS{1'b0}};
    if (en) begin
      onehot[addr] = 1'b1;
    end else begin
      onehot = {RF_NREGS{1'b0}};
    end
  end

endmodule : wr_decode5to32

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
// Arbitrates NREQ register-file write requesters onto one write port.
// Round-robin in ARB; a winner asserting req_lock keeps exclusive access
// (LOCKED) until it drops req_lock or has held the port LOCK_MAX cycles.
//   clk, rst   : clock, synchronous active-high reset
//   req_valid  : in  NREQ     per-requester write request
//   req_lock   : in  NREQ     burst lock request (only the owner's bit matters)
//   req_addr   : in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
//   req_data   : in  NREQ*DW  packed data, requester i at [i*DW +: DW]
//   req_ready  : out NREQ     one-hot grant (combinational)
//   wr_en      : out 1        registered write strobe
//   wr_onehot  : out 32       registered one-hot register select
//   wr_addr    : out AW       registered write address (holds when idle)
//   wr_data    : out DW       registered write data (holds when idle)
//   lock_owner : out NREQ     one-hot lock owner while LOCKED, else zero
// -----------------------------------------------------------------------------
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int AW       = RF_AW,
  parameter int DW       = RF_DW,
  parameter int LOCK_MAX = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ-1:0]     req_lock,
  input  logic [NREQ*AW-1:0]  req_addr,
  input  logic [NREQ*DW-1:0]  req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic                wr_en,
  output logic [RF_NREGS-1:0] wr_onehot,
  output logic [AW-1:0]       wr_addr,
  output logic [DW-1:0]       wr_data,
  output logic [NREQ-1:0]     lock_owner
);

  localparam int            IW         = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0]    LOCK_MAX_C = 8'(LOCK_MAX);
  localparam logic [NREQ-1:0] ONE_OH   = {{(NREQ-1){1'b0}}, 1'b1};

  arb_state_e          state_q, state_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [7:0]          lock_cnt_q, lock_cnt_d;
  logic [7:0]          lock_cnt_inc;
  logic                wr_en_q, wr_en_d;
  logic [AW-1:0]       wr_addr_q, wr_addr_d;
  logic [DW-1:0]       wr_data_q, wr_data_d;
  logic [RF_NREGS-1:0] wr_onehot_q, wr_onehot_d;

  logic                win_found;
  logic [IW-1:0]       win_idx;
  logic [IW-1:0]       xfer_idx;
  logic                xfer;
  logic [NREQ-1:0]     owner_oh;
  logic [NREQ-1:0]     win_oh;
  int                  rr_slot;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] idx);
    if (int'(idx) == NREQ - 1) begin
      return {IW{1'b0}};
    end else begin
      return idx + 1'b1;
    end
  endfunction

  // Round-robin search: first valid requester at or above rr_ptr, wrapping
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr_q;
    rr_slot   = 0;
    for (int k = 0; k < NREQ; k++) begin
      rr_slot = int'(rr_ptr_q) + k;
      if (rr_slot >= NREQ) begin
        rr_slot = rr_slot - NREQ;
      end else begin
        rr_slot = rr_slot;
      end
      if (!win_found && req_valid[rr_slot]) begin
        win_found = 1'b1;
        win_idx   = IW'(rr_slot);
      end else begin
        win_found = win_found;
      end
    end
  end

  assign owner_oh = ONE_OH << owner_q;
  assign win_oh   = ONE_OH << win_idx;

  // Grant: only the owner while LOCKED; never granted during reset
  always_comb begin
    req_ready = {NREQ{1'b0}};
    if (rst) begin
      req_ready = {NREQ{1'b0}};
    end else if (state_q == LOCKED) begin
      req_ready = owner_oh & req_valid;
    end else if (win_found) begin
      req_ready = win_oh;
    end else begin
      req_ready = {NREQ{1'b0}};
    end
  end

  assign xfer     = |req_ready;
  assign xfer_idx = (state_q == LOCKED) ? owner_q : win_idx;

  // Saturating lock counter increment
  assign lock_cnt_inc = (lock_cnt_q >= LOCK_MAX_C) ? LOCK_MAX_C : (lock_cnt_q + 8'd1);

  // FSM, round-robin pointer and lock bookkeeping
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      ARB: begin
        if (xfer) begin
          rr_ptr_d = wrap_inc(win_idx);
          if (req_lock[win_idx]) begin
            state_d    = LOCKED;
            owner_d    = win_idx;
            lock_cnt_d = 8'd1;
          end else begin
            state_d = ARB;
          end
        end else begin
          rr_ptr_d = rr_ptr_q;
        end
      end
      LOCKED: begin
        // The entry transfer counted as 1, so the cycle in which the count
        // reaches LOCK_MAX is the owner's last granted cycle.
        lock_cnt_d = lock_cnt_inc;
        if (!req_lock[owner_q] || (lock_cnt_inc == LOCK_MAX_C)) begin
          state_d  = ARB;
          rr_ptr_d = wrap_inc(owner_q);
        end else begin
          state_d = LOCKED;
        end
      end
      default: begin
        state_d = ARB;
      end
    endcase
  end

  // Output stage next values; address/data hold when no transfer
  always_comb begin
    wr_en_d   = xfer;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (xfer) begin
      wr_addr_d = req_addr[xfer_idx*AW +: AW];
      wr_data_d = req_data[xfer_idx*DW +: DW];
    end else begin
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
    end
  end

  wr_decode5to32 u_decode (
    .en     (wr_en_d),
    .addr   (wr_addr_d[RF_AW-1:0]),
    .onehot (wr_onehot_d)
  );

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB;
      rr_ptr_q    <= {IW{1'b0}};
      owner_q     <= {IW{1'b0}};
      lock_cnt_q  <= 8'd0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= {AW{1'b0}};
      wr_data_q   <= {DW{1'b0}};
      wr_onehot_q <= {RF_NREGS{1'b0}};
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      lock_cnt_q  <= lock_cnt_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_onehot_q <= wr_onehot_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign wr_onehot  = wr_onehot_q;
  assign lock_owner = (state_q == LOCKED) ? owner_oh : {NREQ{1'b0}};

endmodule : regfile_write_arbiter

// File: tb/tb_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_arbiter
// Directed bench for regfile_write_arbiter (NREQ=4, LOCK_MAX=4). Expected
// grants are written out per step; the expected write of each cycle is queued
// when stimulus is driven and compared one clock later.
// -----------------------------------------------------------------------------
module tb_regfile_write_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 5;
  localparam int DW   = 32;

  typedef struct packed {
    logic          en;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_exp_t;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_lock;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               wr_en;
  logic [31:0]        wr_onehot;
  logic [AW-1:0]      wr_addr;
  logic [DW-1:0]      wr_data;
  logic [NREQ-1:0]    lock_owner;

  logic [AW-1:0] a [NREQ];
  logic [DW-1:0] d [NREQ];
  wr_exp_t       sb [$];
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_data;
  int            n_checks;
  int            n_fail;

  regfile_write_arbiter #(
    .NREQ     (NREQ),
    .AW       (AW),
    .DW       (DW),
    .LOCK_MAX (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_lock   (req_lock),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .wr_en      (wr_en),
    .wr_onehot  (wr_onehot),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .lock_owner (lock_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pack();
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW] = a[i];
      req_data[i*DW +: DW] = d[i];
    end
  endtask

  // Called at posedge+1; holds reset for n cycles with every requester valid.
  task automatic do_reset(input int n);
    rst = 1'b1;
    req_valid = 4'b1111;
    req_lock = 4'b0000;
    pack();
    for (int c = 0; c < n; c++) begin
      #4;
      chk("rst_ready", req_ready, 4'b0000);
      @(posedge clk);
      #1;
      chk("rst_wr_en", wr_en, 1'b0);
      chk("rst_onehot", wr_onehot, 32'h0);
      chk("rst_addr", wr_addr, 5'd0);
      chk("rst_data", wr_data, 32'h0);
      chk("rst_owner", lock_owner, 4'b0000);
    end
    rst = 1'b0;
    sb.delete();
    last_addr = 5'd0;
    last_data = 32'h0;
  endtask

  // Called at posedge+1; one directed cycle with expected grant and owner.
  task automatic cycle(input logic [NREQ-1:0] valid, input logic [NREQ-1:0] lock,
                       input logic [NREQ-1:0] exp_ready, input logic [NREQ-1:0] exp_owner);
    wr_exp_t e;
    int w;
    req_valid = valid;
    req_lock = lock;
    pack();
    #4;
    chk("ready", req_ready, exp_ready);
    chk("lock_owner", lock_owner, exp_owner);
    w = -1;
    for (int i = 0; i < NREQ; i++) begin
      if (exp_ready[i]) w = i;
    end
    if (w >= 0) begin
      last_addr = a[w];
      last_data = d[w];
      sb.push_back('{en: 1'b1, addr: a[w], data: d[w]});
    end else begin
      sb.push_back('{en: 1'b0, addr: last_addr, data: last_data});
    end
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("wr_en", wr_en, e.en);
    chk("wr_addr", wr_addr, e.addr);
    chk("wr_data", wr_data, e.data);
    chk("wr_onehot", wr_onehot, e.en ? (32'h1 << e.addr) : 32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    req_valid = 4'b0000;
    req_lock = 4'b0000;
    a[0] = 5'd1;  a[1] = 5'd10; a[2] = 5'd19; a[3] = 5'd28;
    d[0] = 32'h1111_0000; d[1] = 32'h2222_0001;
    d[2] = 32'h3333_0002; d[3] = 32'h4444_0003;
    last_addr = 5'd0;
    last_data = 32'h0;
    pack();
    @(posedge clk);
    #1;

    // Reset with all valid, then round-robin 0,1,2,3,0,1,2,3
    do_reset(3);
    for (int k = 0; k < 8; k++) begin
      cycle(4'b1111, 4'b0000, 4'b0001 << (k % 4), 4'b0000);
    end
    cycle(4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Decode extremes: register 0 and register 31
    do_reset(1);
    d[2] = 32'hDEADBEEF;
    a[2] = 5'd0;
    cycle(4'b0100, 4'b0000, 4'b0100, 4'b0000);
    a[2] = 5'd31;
    cycle(4'b0100, 4'b0000, 4'b0100, 4'b0000);
    cycle(4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Lock burst by requester 1 while requester 3 waits
    do_reset(1);
    cycle(4'b1010, 4'b0010, 4'b0010, 4'b0000);
    cycle(4'b1010, 4'b0010, 4'b0010, 4'b0010);
    cycle(4'b1010, 4'b0000, 4'b0010, 4'b0010);
    cycle(4'b1010, 4'b0000, 4'b1000, 4'b0000);

    // Forced release after LOCK_MAX=4 granted cycles
    do_reset(1);
    cycle(4'b0101, 4'b0001, 4'b0001, 4'b0000);
    cycle(4'b0101, 4'b0001, 4'b0001, 4'b0001);
    cycle(4'b0101, 4'b0001, 4'b0001, 4'b0001);
    cycle(4'b0101, 4'b0001, 4'b0001, 4'b0001);
    cycle(4'b0101, 4'b0001, 4'b0100, 4'b0000);

    // Bubbles while locked, then reset mid-burst
    do_reset(1);
    cycle(4'b0001, 4'b0001, 4'b0001, 4'b0000);
    cycle(4'b1110, 4'b0001, 4'b0000, 4'b0001);
    cycle(4'b1110, 4'b0001, 4'b0000, 4'b0001);
    chk("still_locked", lock_owner, 4'b0001);
    do_reset(1);
    cycle(4'b0110, 4'b0000, 4'b0010, 4'b0000);
    cycle(4'b0110, 4'b0000, 4'b0100, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_regfile_write_arbiter

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter: NREQ, default 4, number of write requesters (2..8).
REQ-002 Parameter: AW, default 5, register address width (fixed 5 for the 32-entry file).
REQ-003 Parameter: DW, default 32, write data width.
REQ-004 Parameter: LOCK_MAX, default 16, maximum consecutive cycles one requester may hold a lock (1..255).
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 req_valid  input  NREQ  per-requester write request.
REQ-008 req_lock  input  NREQ  per-requester burst-lock request, sampled only for the current owner.
REQ-009 req_addr  input  NREQ*AW  packed destination register addresses; requester i in bits [i*AW +: AW].
REQ-010 req_data  input  NREQ*DW  packed write data; requester i in bits [i*DW +: DW].
REQ-011 req_ready  output  NREQ  one-hot grant (or zero), combinational from current state and req_valid.
REQ-012 wr_en  output  1  registered register-file write strobe.
REQ-013 wr_onehot  output  32  registered one-hot decode of wr_addr, gated by wr_en.
REQ-014 wr_addr  output  AW  registered write address.
REQ-015 wr_data  output  DW  registered write data.
REQ-016 lock_owner  output  NREQ  one-hot owner while LOCKED, else zero.

Function
REQ-017 A transfer occurs for requester i in a cycle in which req_valid[i] and req_ready[i] are both 1; at most one transfer per cycle.
REQ-018 In state ARB, req_ready grants the first valid requester found searching upward from rr_ptr with wrap from NREQ-1 to 0; no valid requester -> req_ready = 0.
REQ-019 On every ARB transfer by requester i, rr_ptr becomes (i+1) mod NREQ; with no transfer rr_ptr holds.
REQ-020 Latency exactly 1 cycle: the cycle after a transfer, wr_en = 1, wr_addr/wr_data = winner's addr/data, wr_onehot = 1 << wr_addr (addr 0 -> bit 0, addr 31 -> bit 31).
REQ-021 Cycle after no transfer: wr_en = 0, wr_onehot = 0; wr_addr and wr_data hold previous values.
REQ-022 Register 0 is writable like any other register; no address filtering.
REQ-023 FSM states: ARB, LOCKED.
REQ-024 ARB -> LOCKED when the transfer's requester has req_lock = 1; owner recorded, lock_cnt loaded with 1.
REQ-025 In LOCKED only the owner may be granted: req_ready = owner one-hot & req_valid; other requesters wait regardless of validity.
REQ-026 In LOCKED, lock_cnt increments every cycle, saturating at LOCK_MAX.
REQ-027 LOCKED -> ARB when owner's req_lock = 0; a same-cycle owner transfer is still granted and is the last of the burst.
REQ-028 LOCKED -> ARB when lock_cnt = LOCK_MAX (forced release): owner transfer allowed that cycle; rr_ptr := (owner+1) mod NREQ.
REQ-029 In LOCKED with owner req_valid = 0, no grant; state held (lock persists through bubbles until REQ-027/028).
REQ-030 On any LOCKED -> ARB exit, rr_ptr := (owner+1) mod NREQ.
REQ-031 lock_owner = owner one-hot while in LOCKED, 0 in ARB.
REQ-032 req_ready never depends on req_addr or req_data.

Reset
REQ-033 While rst = 1: req_ready = 0, no transfer accepted.
REQ-034 On a clock edge with rst = 1: state = ARB, rr_ptr = 0, lock_cnt = 0, owner = 0, wr_en = 0, wr_onehot = 0, wr_addr = 0, wr_data = 0, lock_owner = 0.
REQ-035 Reset mid-burst or mid-write discards the lock and any pending output write; first cycle after release behaves as ARB with rr_ptr = 0.

Structure
REQ-036 Shared package regfile_arb_pkg holds AW, DW, register count 32, and the state enum {ARB, LOCKED}.
REQ-037 One sub-module: wr_decode5to32, combinational 5-bit to 32-bit one-hot decoder with enable; output 0 when enable = 0.
REQ-038 Round-robin search, FSM, lock counter and output register stage live in the top module.

Verification
REQ-039 Reset: assert rst 3 cycles with all req_valid = 1 -> req_ready = 0, all outputs 0 throughout, first post-reset grant to requester 0.
REQ-040 Round-robin: req_valid = 4'b1111 held 8 cycles, no locks -> grants 0,1,2,3,0,1,2,3; wr_onehot = 1 << each addr one cycle later.
REQ-041 Decode: requester 2 writes addr 0, then 31, data 0xDEADBEEF -> wr_onehot 0x00000001, then 0x80000000, wr_data 0xDEADBEEF, wr_en 1 each.
REQ-042 Lock burst: requester 1 lock = 1 for 3 transfers, requester 3 valid throughout -> 1,1,1 (lock=0 on third), then 3; lock_owner = 4'b0010 during burst.
REQ-043 Forced release: LOCK_MAX = 4, requester 0 holds lock and valid continuously, requester 2 valid -> requester 0 granted 4 cycles, then requester 2 granted.
REQ-044 Bubble and reset mid-lock: owner drops valid 2 cycles while locked -> no grants, state LOCKED; rst asserted mid-burst -> lock_owner = 0, wr_en = 0 next cycle.
